// File: rtl/activation_skewer_if.sv
// Activation stream interface between a row producer and the skewer.
// The producer (master) offers one activation row per cycle; the skewer
// (slave) returns the skewed lanes plus status toward the PE array.
interface activation_skewer_if #(
    parameter int ARRAY_SIZE         = 2,
    parameter int COMPUTE_DATA_WIDTH = 4
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic signed [COMPUTE_DATA_WIDTH-1:0] in_row [ARRAY_SIZE];
    logic                                 in_last;
    logic signed [COMPUTE_DATA_WIDTH-1:0] ins [ARRAY_SIZE];
    logic                                 compute;
    logic                                 busy;
    logic                                 done;

    modport master (
        output in_valid, in_row, in_last,
        input  in_ready, ins, compute, busy, done
    );

    modport slave (
        input  in_valid, in_row, in_last,
        output in_ready, ins, compute, busy, done
    );
endinterface

// File: rtl/activation_skewer.sv
// Activation skewer: staggers each accepted activation row across the
// lanes of a systolic PE array so that lane i sees its element i edges
// after lane 0. A small FSM frames a tile, stops accepting after the last
// row, waits for the lanes to drain and then pulses done for one cycle.
module activation_skewer #(
    parameter int ARRAY_SIZE         = 2,
    parameter int COMPUTE_DATA_WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    activation_skewer_if.slave bus
);

    localparam int CNT_W = $clog2(ARRAY_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_compute;

    logic                  w_accept;
    logic [ARRAY_SIZE-1:0] w_last_valid_next;
    logic                  w_compute_next;

    // Acceptance uses the registered ready, so there is no input->output path.
    assign w_accept = bus.in_valid && r_in_ready;

    // Per-lane delay lines: lane g holds g+1 stages of data plus valid.
    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
        logic signed [COMPUTE_DATA_WIDTH-1:0] r_data [g+1];
        logic [g:0]                           r_valid;
        logic signed [COMPUTE_DATA_WIDTH-1:0] w_head_data;

        // A bubble carries zero data so invalid stages never hold stale values.
        assign w_head_data = w_accept ? bus.in_row[g] : '0;

        // Shift the lane by one stage each edge; the head takes a row or a bubble.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // NOTE: the lane stages are cleared on reset because reset must
                // discard in-flight data; a plain storage array would not need it.
                for (int k = 0; k <= g; k++) begin
                    r_data[k] <= '0;
                end
                r_valid <= '0;
            end else begin
                // NOTE: non-blocking assignments make every stage read its
                // predecessor's old value, giving a true shift register.
                r_data[0]  <= w_head_data;
                r_valid[0] <= w_accept;
                for (int k = 1; k <= g; k++) begin
                    r_data[k]  <= r_data[k-1];
                    r_valid[k] <= r_valid[k-1];
                end
            end
        end

        assign bus.ins[g] = r_valid[g] ? r_data[g] : '0;

        // Value the lane's output valid bit takes at the coming edge.
        if (g == 0) begin : g_first
            assign w_last_valid_next[g] = w_accept;
        end else begin : g_rest
            assign w_last_valid_next[g] = r_valid[g-1];
        end
    end

    // OR of the lane output valid bits as they will be after the next edge.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned
        // and no latch is inferred.
        w_compute_next = 1'b0;
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            w_compute_next = w_compute_next | w_last_valid_next[k];
        end
    end

    // Register compute so it changes on the same edge as the lane outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_compute <= 1'b0;
        end else begin
            r_compute <= w_compute_next;
        end
    end

    // Tile-framing FSM with registered ready/busy/done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        if (bus.in_last) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= CNT_W'(1);
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (w_accept && bus.in_last) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= CNT_W'(1);
                        r_in_ready  <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The acceptance edge counts as the first drain edge.
                    if (r_drain_cnt == CNT_W'(ARRAY_SIZE)) begin
                        r_state     <= DONE;
                        r_drain_cnt <= '0;
                        r_done      <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_drain_cnt <= '0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.compute  = r_compute;

endmodule
